// File: rtl/uart_tx_arbiter_if.sv
// Requester/line bundle for the shared UART TX arbiter.
// slave = arbiter side, master = requesters and line observer.
interface uart_tx_arbiter_if;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [1:0]  done_chan;

  modport master (
    output req_valid, req_data,
    input  req_ready, grant, tx, busy, tx_done, done_chan
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, grant, tx, busy, tx_done, done_chan
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one 8N1 TX line between three
// valid/ready byte requesters, one frame per grant.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_CH       = 3
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [1:0]        last_grant;
  logic [1:0]        sel;
  logic              sel_ok;
  logic              bit_end;
  logic [7:0]        byte_in;
  logic [NUM_CH-1:0] v;

  assign v       = bus.req_valid;
  assign bit_end = (cnt == LAST);
  assign sel_ok  = (state == IDLE) && (|v);

  // search starts just past the previous owner, with wrap
  always_comb begin
    case (last_grant)
      2'd0:    sel = v[1] ? 2'd1 : (v[2] ? 2'd2 : 2'd0);
      2'd1:    sel = v[2] ? 2'd2 : (v[0] ? 2'd0 : 2'd1);
      default: sel = v[0] ? 2'd0 : (v[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    case (sel)
      2'd1:    byte_in = bus.req_data[15:8];
      2'd2:    byte_in = bus.req_data[23:16];
      default: byte_in = bus.req_data[7:0];
    endcase
  end

  assign bus.req_ready = (sel_ok && reset) ? (3'b001 << sel) : 3'b000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      last_grant    <= 2'd2;
      bus.tx        <= 1'b1;
      bus.busy      <= 1'b0;
      bus.grant     <= 3'b000;
      bus.tx_done   <= 1'b0;
      bus.done_chan <= 2'd0;
    end else begin
      bus.tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.tx  <= 1'b1;
          cnt     <= '0;
          bit_idx <= '0;
          if (sel_ok) begin
            shift      <= byte_in;
            last_grant <= sel;
            bus.grant  <= 3'b001 << sel;
            bus.busy   <= 1'b1;
            bus.tx     <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          cnt <= cnt + 1'b1;
          if (bit_end) begin
            cnt    <= '0;
            bus.tx <= shift[0];
            state  <= DATA;
          end
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (bit_end) begin
            cnt     <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              bus.tx <= 1'b1;
              state  <= STOP;
            end else begin
              bus.tx <= shift[1];
            end
          end
        end
        STOP: begin
          cnt <= cnt + 1'b1;
          if (bit_end) begin
            cnt           <= '0;
            bus.tx_done   <= 1'b1;
            bus.done_chan <= last_grant;
            bus.grant     <= 3'b000;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLKS_PER_BIT=4:
// frame table plus withdrawal and mid-frame reset sequences.
module tb_uart_tx_arbiter;
  localparam int CPB = 4;
  localparam int FR  = 10 * CPB;
  localparam int NV  = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   n, bad;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .NUM_CH(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rst_before;
    logic        cont;
    logic [2:0]  valid;
    logic [23:0] data;
    logic [2:0]  exp_ready;
    logic [7:0]  exp_byte;
    logic [1:0]  exp_chan;
  } vec_t;

  vec_t tab[NV];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input logic [2:0] v, input logic [23:0] d);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = v;
    bus.req_data  = d;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_accept();
    n = 0;
    while (bus.req_ready === 3'b000 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_entry(input int i);
    logic [9:0] w, cap;
    int glitch, cbad;
    if (tab[i].rst_before) do_reset(tab[i].valid, tab[i].data);
    wait_accept();
    chk("req_ready", {29'd0, bus.req_ready}, {29'd0, tab[i].exp_ready});
    if (tab[i].cont) chk("frame_gap", cyc - last_acc, FR + 1);
    last_acc = cyc;
    @(posedge clk); #1;
    if (i + 1 < NV && !tab[i+1].rst_before) begin
      bus.req_valid = tab[i+1].valid;
      bus.req_data  = tab[i+1].data;
    end else begin
      bus.req_valid = 3'b000;
    end
    w = {1'b1, tab[i].exp_byte, 1'b0};
    cap = '0;
    glitch = 0;
    cbad = 0;
    for (int c = 1; c <= FR; c++) begin
      @(negedge clk);
      if (bus.tx !== w[(c-1)/CPB]) glitch++;
      if (((c-1) % CPB) == 1) cap[(c-1)/CPB] = bus.tx;
      if (bus.grant !== tab[i].exp_ready || bus.busy !== 1'b1 ||
          bus.tx_done !== 1'b0 || bus.req_ready !== 3'b000) cbad++;
    end
    chk("frame_bits", {22'd0, cap}, {22'd0, w});
    chk("frame_glitch", glitch, 0);
    chk("frame_ctl", cbad, 0);
    @(negedge clk);
    chk("tx_done", {31'd0, bus.tx_done}, 1);
    chk("done_chan", {30'd0, bus.done_chan}, {30'd0, tab[i].exp_chan});
    chk("end_grant", {29'd0, bus.grant}, 0);
    chk("end_busy", {31'd0, bus.busy}, 0);
    chk("end_tx", {31'd0, bus.tx}, 1);
  endtask

  initial begin
    tab[0] = '{1'b1, 1'b0, 3'b010, 24'h00A500, 3'b010, 8'hA5, 2'd1};
    tab[1] = '{1'b1, 1'b0, 3'b111, 24'h332211, 3'b001, 8'h11, 2'd0};
    tab[2] = '{1'b0, 1'b1, 3'b111, 24'h332211, 3'b010, 8'h22, 2'd1};
    tab[3] = '{1'b0, 1'b1, 3'b111, 24'h332211, 3'b100, 8'h33, 2'd2};
    tab[4] = '{1'b0, 1'b1, 3'b111, 24'h332211, 3'b001, 8'h11, 2'd0};
    tab[5] = '{1'b1, 1'b0, 3'b101, 24'hC3FF5A, 3'b001, 8'h5A, 2'd0};
    tab[6] = '{1'b0, 1'b1, 3'b101, 24'hC3FF5A, 3'b100, 8'hC3, 2'd2};
    tab[7] = '{1'b0, 1'b1, 3'b101, 24'hC3FF5A, 3'b001, 8'h5A, 2'd0};
    tab[8] = '{1'b0, 1'b1, 3'b101, 24'hC3FF5A, 3'b100, 8'hC3, 2'd2};

    bus.req_valid = 3'b000;
    bus.req_data  = 24'h0;
    repeat (2) @(negedge clk);
    chk("rst_tx", {31'd0, bus.tx}, 1);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_grant", {29'd0, bus.grant}, 0);
    chk("rst_ready", {29'd0, bus.req_ready}, 0);
    chk("rst_done", {31'd0, bus.tx_done}, 0);
    chk("rst_chan", {30'd0, bus.done_chan}, 0);

    @(posedge clk); #1;
    reset = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 ||
          bus.grant !== 3'b000 || bus.req_ready !== 3'b000) bad++;
    end
    chk("idle50", bad, 0);

    for (int i = 0; i < NV; i++) run_entry(i);

    // withdrawal: ch2 raises and drops valid during a ch0 frame
    do_reset(3'b001, 24'h77003C);
    wait_accept();
    chk("wd_accept", {29'd0, bus.req_ready}, 3'b001);
    @(posedge clk); #1;
    bus.req_valid = 3'b100;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.req_ready !== 3'b000) bad++;
    end
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    n = 0;
    while (bus.tx_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      if (bus.req_ready !== 3'b000) bad++;
      n++;
    end
    chk("wd_done", {31'd0, bus.tx_done}, 1);
    chk("wd_no_ready", bad, 0);
    chk("wd_idle_ready", {29'd0, bus.req_ready}, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.req_ready !== 3'b000 ||
          bus.busy !== 1'b0 || bus.grant !== 3'b000) bad++;
    end
    chk("wd_idle", bad, 0);

    // reset during DATA bit 3 of a ch1 frame (0x96, bit3 = 0)
    do_reset(3'b010, 24'h009600);
    wait_accept();
    chk("mr_accept", {29'd0, bus.req_ready}, 3'b010);
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    repeat (17) @(negedge clk);
    chk("mr_bit3", {31'd0, bus.tx}, 0);
    chk("mr_grant_pre", {29'd0, bus.grant}, 3'b010);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_data  = 24'h332211;
    #1;
    chk("mr_tx", {31'd0, bus.tx}, 1);
    chk("mr_busy", {31'd0, bus.busy}, 0);
    chk("mr_grant", {29'd0, bus.grant}, 0);
    chk("mr_ready", {29'd0, bus.req_ready}, 0);
    chk("mr_done", {31'd0, bus.tx_done}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_first_ready", {29'd0, bus.req_ready}, 3'b001);
    @(negedge clk);
    chk("mr_first_grant", {29'd0, bus.grant}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART 8N1 transmit line between three byte requesters. Requesters use a valid/ready handshake. A round-robin arbiter grants one requester per frame. An internal baud-counted serializer then shifts out start bit, 8 data bits LSB first, and stop bit. The block sits between the three channel byte sources and the board TX pin, and replaces the per-channel direct drive with a single sequenced line.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
NUM_CH, 3, requester count; fixed at 3 for this revision, other values illegal.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous reset, active-low
req_valid  input  3  per-channel "byte available"; bit i = channel i
req_data  input  24  channel i byte on bits [8i+7:8i]
req_ready  output  3  one-cycle accept pulse to the granted channel
grant  output  3  one-hot owner of the current frame; 000 when idle
tx  output  1  serial line, idle high
busy  output  1  high from the cycle after accept until the last stop-bit cycle, inclusive
tx_done  output  1  one-cycle pulse after the stop bit completes
done_chan  output  2  channel id of the finished frame; valid while tx_done=1

Behaviour:
- Reset (reset=0, async) forces: tx=1, busy=0, grant=000, req_ready=000, tx_done=0, done_chan=00, state=IDLE, baud counter=0, bit index=0. The round-robin pointer is set so channel 0 has top priority (last_grant=2).
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching from (last_grant+1) mod 3 upward, with wrap.
  - In the same cycle: req_ready[i]=1 and req_data[i] is latched into the shift register.
  - On the next edge: grant=one-hot(i), last_grant=i, state=START.
  - If no request is pending, tx=1 and busy=0.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle: tx_done=1 on the next edge, done_chan=i, grant=000, state=IDLE.
- Timing:
  - The first START cycle is the cycle after req_ready.
  - Frame length on the line is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 1 idle-high cycle (the IDLE arbitration cycle, coincident with tx_done).
  - Sustained throughput is 1 byte per 10*CLKS_PER_BIT+1 cycles.
- Handshake rules:
  - A requester holds req_valid and its byte stable until it sees req_ready.
  - Deasserting req_valid before acceptance is allowed and withdraws the request; nothing is sent.
  - req_valid and req_data are ignored outside IDLE.
  - req_ready is never asserted outside IDLE and never on more than one bit.
- Fairness: a continuously requesting channel waits at most 2 frames.
- Simultaneous events: all three valid in the same IDLE cycle resolve purely by the pointer; ties are impossible.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps on bit boundaries; width is ceil(log2(CLKS_PER_BIT)).
- Reset mid-frame:
  - tx returns high immediately (asynchronously).
  - The frame is abandoned with no tx_done.
  - The pointer returns to its reset value.
  - A byte already accepted is lost; the requester is not re-notified.

Test Plan (CLKS_PER_BIT=4):
1. Reset release, no requests for 50 cycles -> tx=1, busy=0, grant=000, req_ready=000 throughout.
2. Single request: req_valid=010, ch1 byte 8'hA5 -> req_ready=010 for 1 cycle; tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total); grant=010 during the frame; tx_done pulse with done_chan=1 at cycle 41 after accept.
3. All valid continuously, bytes 11/22/33 -> frames in order ch0, ch1, ch2, ch0...; exactly 1 idle cycle between frames; each channel gets one req_ready per 3 frames.
4. Fairness: req_valid=101 held -> grant sequence 001, 100, 001, 100; ch1 is never granted.
5. Withdrawal: during a ch0 frame, ch2 asserts valid then drops it before frame end -> next IDLE selects nothing, tx stays high, no req_ready[2].
6. Reset mid-frame: assert reset during DATA bit 3 of a ch1 frame -> tx=1, busy=0, grant=000 immediately. After release with req_valid=111, ch0 is granted first.
